// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if
// Purpose: groups the scan request, the select/sample path to the 8:1 mux and
// the snapshot result of mux_scan_ctrl into one bundle.
// Signals:
//   start     scan request (sampled by the controller only while idle)
//   chan_en   per-channel enable mask, bit n = channel n
//   y_in      mux output y, fed back to the controller
//   s0,s1,s2  mux select lines, s0 is the LSB
//   data_out  last completed scan, bit n = sampled value of channel n
//   valid     one-cycle pulse when data_out updates
//   busy      high while a scan is in progress
// Modports:
//   master    the environment: requester plus the mux itself (drives y_in)
//   slave     the scan controller
interface mux_scan_ctrl_if;
  logic       start;
  logic [7:0] chan_en;
  logic       y_in;
  logic       s0;
  logic       s1;
  logic       s2;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;

  modport master (
    output start, chan_en, y_in,
    input  s0, s1, s2, data_out, valid, busy
  );

  modport slave (
    input  start, chan_en, y_in,
    output s0, s1, s2, data_out, valid, busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
// Purpose: sequences the select lines of an 8:1 mux over every enabled
// channel in ascending order, lets each select settle for HOLD_CYCLES cycles,
// samples y once per channel and publishes the eight samples as one word.
// Ports:
//   clk  single clock, all state updates on the rising edge
//   rst  asynchronous active-high reset
//   bus  mux_scan_ctrl_if.slave: start/chan_en request, y_in from the mux,
//        s0..s2 to the mux, data_out/valid/busy result
// Parameters:
//   HOLD_CYCLES  settle cycles with select stable before sampling (0..15)
module mux_scan_ctrl #(
  parameter int HOLD_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  mux_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  // With no settle interval a new select goes straight to its sample cycle.
  localparam state_t     AFTER_SELECT = (HOLD_CYCLES == 0) ? SAMPLE : SETTLE;
  localparam logic [3:0] HOLD_LAST    = (HOLD_CYCLES == 0) ? 4'd0
                                                           : 4'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;

  logic [2:0] first_ch;
  logic [2:0] next_ch;
  logic       next_found;
  logic [7:0] shadow_merged;

  // Lowest enabled channel of the incoming mask; the descending loop lets the
  // lowest set bit win.
  always_comb begin
    first_ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.chan_en[i]) begin
        first_ch = 3'(i);
      end
    end
  end

  // Lowest latched channel strictly above the current select, so disabled
  // channels are skipped without spending any cycles on them.
  always_comb begin
    next_ch    = 3'd0;
    next_found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(sel_q))) begin
        next_ch    = 3'(i);
        next_found = 1'b1;
      end
    end
  end

  // Shadow word with the bit being sampled right now already merged in, so
  // the final channel lands in data_out on the same edge it is sampled.
  always_comb begin
    shadow_merged         = shadow_q;
    shadow_merged[sel_q]  = bus.y_in;
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mask_d   = bus.chan_en;
          shadow_d = 8'h00;
          cnt_d    = 4'd0;
          if (bus.chan_en != 8'h00) begin
            busy_d  = 1'b1;
            sel_d   = first_ch;
            state_d = AFTER_SELECT;
          end else begin
            // An empty mask completes immediately with an all-zero snapshot.
            data_d  = 8'h00;
            valid_d = 1'b1;
          end
        end
      end

      SETTLE: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = 4'd0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      SAMPLE: begin
        shadow_d = shadow_merged;
        cnt_d    = 4'd0;
        if (next_found) begin
          sel_d   = next_ch;
          state_d = AFTER_SELECT;
        end else begin
          data_d  = shadow_merged;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          sel_d   = 3'd0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any scan without a valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 3'd0;
      cnt_q    <= 4'd0;
      mask_q   <= 8'h00;
      shadow_q <= 8'h00;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.s0       = sel_q[0];
  assign bus.s1       = sel_q[1];
  assign bus.s2       = sel_q[2];
  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl
// Purpose: self-checking bench for mux_scan_ctrl with HOLD_CYCLES=2. An 8:1
// mux model closes the loop from the select lines back to y_in. Table-driven
// scans check snapshot value, latency, busy length, visit order and per-channel
// hold time; hand-written sequences cover reset, mid-scan reset and start
// requests while busy or on the valid cycle.
module tb_mux_scan_ctrl;

  localparam int HOLD    = 2;
  localparam int PER_CH  = HOLD + 1;
  localparam int BUDGET  = 200;

  logic       clk;
  logic       rst;
  logic [7:0] mux_in;
  logic       noise;
  logic [2:0] sel;

  mux_scan_ctrl_if bus ();

  mux_scan_ctrl #(.HOLD_CYCLES(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // The mux under control; noise corrupts y only while the select is settling,
  // so a controller that samples early picks up wrong bits.
  assign sel      = {bus.s2, bus.s1, bus.s0};
  assign bus.y_in = mux_in[sel] ^ noise;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] inputs;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  int errors = 0;
  int checks = 0;

  logic [7:0] mon_data;
  int         mon_valid_off;
  int         mon_busy;
  logic [7:0] mon_visited;
  bit         mon_order_ok;
  int         mon_hold[8];

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Raise start just after edge k so the controller samples it at edge k+1.
  task automatic apply_stimulus(input logic [7:0] mask);
    @(posedge clk); #1;
    bus.chan_en = mask;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.chan_en = ~mask;
  endtask

  // Observes one scan starting just after edge k+1 (offset 1) until valid.
  // With poke set, start is pulsed while busy with a different mask.
  task automatic monitor_scan(input bit poke);
    int off;
    int prev;
    mon_valid_off = -1;
    mon_busy      = 0;
    mon_visited   = 8'h00;
    mon_order_ok  = 1'b1;
    mon_data      = 8'hxx;
    prev          = -1;
    for (int i = 0; i < 8; i++) mon_hold[i] = 0;
    off = 1;
    while (off <= BUDGET) begin
      if (bus.valid) begin
        mon_valid_off = off;
        mon_data      = bus.data_out;
        break;
      end
      if (bus.busy) begin
        mon_busy++;
        if (int'(sel) != prev) begin
          if (int'(sel) < prev) mon_order_ok = 1'b0;
          prev = int'(sel);
        end
        mon_visited[sel] = 1'b1;
        mon_hold[sel]++;
        noise = (mon_hold[sel] < PER_CH);
        if (poke) begin
          bus.start   = (off % 5 == 0);
          bus.chan_en = 8'h01;
        end
      end else begin
        noise = 1'b0;
      end
      @(posedge clk); #1;
      off++;
    end
    noise = 1'b0;
    if (poke) bus.start = 1'b0;
  endtask

  task automatic check_scan(input string tag, input logic [7:0] mask,
                            input logic [7:0] exp_data);
    int n;
    n = $countones(mask);
    check_output({tag, " data_out"}, mon_data, exp_data);
    check_output({tag, " valid offset"}, mon_valid_off, 1 + n * PER_CH);
    check_output({tag, " busy cycles"}, mon_busy, n * PER_CH);
    check_output({tag, " visited"}, mon_visited, mask);
    check_output({tag, " ascending"}, mon_order_ok, 1);
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("%s hold ch%0d", tag, i), mon_hold[i],
                   mask[i] ? PER_CH : 0);
    end
  endtask

  initial begin
    int rst_valid_seen;

    // i0..i7 = 0,1,0,1,1,0,1,0 -> 0x5A
    vecs[0] = '{8'hFF, 8'h5A, 8'h5A};
    vecs[1] = '{8'h0F, 8'h5A, 8'h0A};
    vecs[2] = '{8'h81, 8'h5A, 8'h00};
    vecs[3] = '{8'h81, 8'hDA, 8'h80};
    vecs[4] = '{8'h00, 8'h5A, 8'h00};
    vecs[5] = '{8'h24, 8'hFF, 8'h24};
    vecs[6] = '{8'hFF, 8'hA5, 8'hA5};

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.chan_en = 8'h00;
    mux_in      = 8'h00;
    noise       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset sel", sel, 3'd0);
    check_output("reset busy", bus.busy, 1'b0);
    check_output("reset valid", bus.valid, 1'b0);
    check_output("reset data_out", bus.data_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      mux_in = vecs[v].inputs;
      apply_stimulus(vecs[v].mask);
      monitor_scan(1'b0);
      check_scan($sformatf("vec%0d", v), vecs[v].mask, vecs[v].exp_data);
      @(posedge clk); #1;
      check_output($sformatf("vec%0d valid one cycle", v), bus.valid, 1'b0);
      check_output($sformatf("vec%0d data_out holds", v), bus.data_out,
                   vecs[v].exp_data);
    end

    // Reset in the middle of an all-ones scan.
    mux_in = 8'hFF;
    apply_stimulus(8'hFF);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("midrst sel", sel, 3'd0);
    check_output("midrst busy", bus.busy, 1'b0);
    check_output("midrst data_out", bus.data_out, 8'h00);
    check_output("midrst valid", bus.valid, 1'b0);
    rst_valid_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.valid) rst_valid_seen++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.valid || bus.busy) rst_valid_seen++;
    end
    check_output("midrst no valid", rst_valid_seen, 0);
    apply_stimulus(8'hFF);
    monitor_scan(1'b0);
    check_scan("postrst", 8'hFF, 8'hFF);

    // Start pulses while busy are ignored; a start on the valid cycle is taken.
    mux_in = 8'h5A;
    apply_stimulus(8'hFF);
    monitor_scan(1'b1);
    check_scan("poke", 8'hFF, 8'h5A);
    bus.chan_en = 8'hFF;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.chan_en = 8'h00;
    check_output("restart busy", bus.busy, 1'b1);
    check_output("restart valid", bus.valid, 1'b0);
    check_output("restart data holds", bus.data_out, 8'h5A);
    monitor_scan(1'b0);
    check_scan("restart", 8'hFF, 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
